// File: rtl/stopwatch_cu.sv
// -----------------------------------------------------------------------------
// stopwatch_cu
//
// Control unit and time base for the stopwatch. Button levels from the
// debouncers are edge-detected and drive a STOP/RUN/CLEAR state machine. The
// unit keeps the centisecond, second and minute counters and produces the
// binary value shown by the FND controller.
//
// Parameters:
//   TICK_COUNT   clk cycles per centisecond tick (1_000_000 at 100 MHz)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   btn_run       in   debounced run/stop level; rising edge toggles run/stop
//   btn_clear     in   debounced clear level; rising edge requests clear
//   display_mode  in   0: show SS.CC, 1: show MM.SS
//   bcd           out  [13:0] binary display value (0..5999)
//   run_led       out  high while the FSM is in RUN
//   wrap_pulse    out  one-cycle pulse on the 59:59.99 -> 00:00.00 rollover
// -----------------------------------------------------------------------------
module stopwatch_cu #(
    parameter int TICK_COUNT = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_clear,
    input  logic        display_mode,
    output logic [13:0] bcd,
    output logic        run_led,
    output logic        wrap_pulse
);

    localparam int                TICK_W   = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_COUNT - 1);

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic              btn_run_d;
    logic              btn_clear_d;
    logic              edge_armed;
    logic              run_edge;
    logic              clear_edge;

    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_next;
    logic [6:0]        cs_cnt;
    logic [6:0]        cs_next;
    logic [5:0]        sec_cnt;
    logic [5:0]        sec_next;
    logic [5:0]        min_cnt;
    logic [5:0]        min_next;
    logic              tick;
    logic              wrap_next;
    logic [13:0]       bcd_next;

    // ------------------------------------------------------------------
    // Button edge detection. edge_armed is low only in the first cycle
    // after reset release, so a button held through reset is not taken
    // as a fresh press; the delay registers still sample in that cycle.
    // ------------------------------------------------------------------
    assign run_edge   = btn_run   & ~btn_run_d   & edge_armed;
    assign clear_edge = btn_clear & ~btn_clear_d & edge_armed;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_run_d   <= 1'b0;
            btn_clear_d <= 1'b0;
            edge_armed  <= 1'b0;
        end else begin
            btn_run_d   <= btn_run;
            btn_clear_d <= btn_clear;
            edge_armed  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. Clear wins over a simultaneous run edge in STOP;
    // clear is ignored in RUN; CLEAR always falls back to STOP and drops
    // any edge seen while in it.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            STOP: begin
                if (clear_edge)    next_state = CLEAR;
                else if (run_edge) next_state = RUN;
            end
            RUN: begin
                if (run_edge)      next_state = STOP;
            end
            CLEAR:                 next_state = STOP;
            default:               next_state = STOP;
        endcase
    end

    // ------------------------------------------------------------------
    // Time base and cascaded time counters. The tick counter holds in
    // STOP so a resumed run keeps the partial centisecond.
    // ------------------------------------------------------------------
    assign tick = (state == RUN) && (tick_cnt == TICK_MAX);

    always_comb begin
        tick_next = tick_cnt;
        cs_next   = cs_cnt;
        sec_next  = sec_cnt;
        min_next  = min_cnt;
        wrap_next = 1'b0;

        if (state == CLEAR) begin
            tick_next = '0;
            cs_next   = '0;
            sec_next  = '0;
            min_next  = '0;
        end else if (state == RUN) begin
            tick_next = tick ? '0 : tick_cnt + TICK_W'(1);
            if (tick) begin
                if (cs_cnt == 7'd99) begin
                    cs_next = '0;
                    if (sec_cnt == 6'd59) begin
                        sec_next = '0;
                        if (min_cnt == 6'd59) begin
                            min_next  = '0;
                            wrap_next = 1'b1;
                        end else begin
                            min_next = min_cnt + 6'd1;
                        end
                    end else begin
                        sec_next = sec_cnt + 6'd1;
                    end
                end else begin
                    cs_next = cs_cnt + 7'd1;
                end
            end
        end
    end

    // Display value from the current counter registers; max 59*100+99.
    always_comb begin
        if (display_mode) bcd_next = 14'(min_cnt) * 14'd100 + 14'(sec_cnt);
        else              bcd_next = 14'(sec_cnt) * 14'd100 + 14'(cs_cnt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= STOP;
            tick_cnt   <= '0;
            cs_cnt     <= '0;
            sec_cnt    <= '0;
            min_cnt    <= '0;
            bcd        <= '0;
            run_led    <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state      <= next_state;
            tick_cnt   <= tick_next;
            cs_cnt     <= cs_next;
            sec_cnt    <= sec_next;
            min_cnt    <= min_next;
            bcd        <= bcd_next;
            run_led    <= (next_state == RUN);
            wrap_pulse <= wrap_next;
        end
    end

endmodule

// File: tb/tb_stopwatch_cu.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_cu
//
// Self-checking bench for stopwatch_cu. The bench keeps its own count of clock
// edges spent running (run_cycles); elapsed centiseconds are run_cycles /
// TICK_COUNT and the expected display is derived arithmetically from that.
// Expected display values are queued when the stimulus is applied and popped
// and compared one clock later, when the registered bcd output reflects them.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_cu;

    localparam int T       = 4;
    localparam int WRAP_CS = 60 * 60 * 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_run;
    logic        btn_clear;
    logic        display_mode;
    logic [13:0] bcd;
    logic        run_led;
    logic        wrap_pulse;

    int checks     = 0;
    int failures   = 0;
    int run_cycles = 0;
    bit running    = 1'b0;

    typedef struct {
        string tag;
        int    value;
    } exp_t;

    exp_t exp_q[$];

    stopwatch_cu #(.TICK_COUNT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_run      (btn_run),
        .btn_clear    (btn_clear),
        .display_mode (display_mode),
        .bcd          (bcd),
        .run_led      (run_led),
        .wrap_pulse   (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int model_bcd(input int rc, input bit mode);
        int t;
        int cs;
        int sec;
        int mn;
        t   = rc / T;
        cs  = t % 100;
        sec = (t / 100) % 60;
        mn  = (t / 6000) % 60;
        return mode ? mn * 100 + sec : sec * 100 + cs;
    endfunction

    // One rising edge; an edge taken while the FSM runs advances the time base.
    task automatic cycle();
        @(posedge clk);
        if (running) run_cycles++;
        @(negedge clk);
    endtask

    task automatic expect_bcd(input string tag);
        exp_t e;
        e.tag   = tag;
        e.value = model_bcd(run_cycles, display_mode);
        exp_q.push_back(e);
        cycle();
        e = exp_q.pop_front();
        check(e.tag, 32'(bcd), e.value);
    endtask

    task automatic pulse_run();
        btn_run = 1'b1;
        cycle();
        running = ~running;
        btn_run = 1'b0;
        cycle();
    endtask

    task automatic pulse_clear();
        btn_clear = 1'b1;
        cycle();
        btn_clear = 1'b0;
        cycle();
        if (!running) run_cycles = 0;
    endtask

    initial begin
        int  held;
        bit  changed;
        bit  hit;

        reset        = 1'b0;
        btn_run      = 1'b1;
        btn_clear    = 1'b0;
        display_mode = 1'b0;

        // Reset with btn_run held high.
        repeat (5) @(negedge clk);
        check("rst_bcd",  32'(bcd),        0);
        check("rst_led",  32'(run_led),    0);
        check("rst_wrap", 32'(wrap_pulse), 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("held_no_edge", 32'(run_led), 0);
        end
        btn_run = 1'b0;
        cycle();
        expect_bcd("idle_bcd");

        // Run for 600 edges at TICK_COUNT=4 -> 1.50.
        pulse_run();
        check("run_led_on", 32'(run_led), 1);
        while (run_cycles < 600) cycle();
        expect_bcd("run_model_150");
        check("run_bcd_150", 32'(bcd), 150);

        // Stop, hold, resume.
        pulse_run();
        check("stop_led", 32'(run_led), 0);
        expect_bcd("stop_hold_a");
        held = int'(bcd);
        repeat (100) cycle();
        check("stop_const", 32'(bcd), held);
        pulse_run();
        changed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (int'(bcd) != held) begin
                changed = 1'b1;
                break;
            end
            cycle();
        end
        check("resume_tick", 32'(changed), 1);
        expect_bcd("resume_bcd");

        // Clear while running is ignored.
        repeat (37) cycle();
        pulse_clear();
        check("clear_in_run_led", 32'(run_led), 1);
        expect_bcd("clear_in_run_bcd");

        // Clear from STOP.
        pulse_run();
        pulse_clear();
        expect_bcd("clear_bcd");
        check("clear_led", 32'(run_led), 0);

        // Simultaneous run and clear from STOP with non-zero counters.
        pulse_run();
        repeat (40) cycle();
        pulse_run();
        btn_run   = 1'b1;
        btn_clear = 1'b1;
        cycle();
        check("both_led_clear", 32'(run_led), 0);
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        cycle();
        run_cycles = 0;
        check("both_led_stop", 32'(run_led), 0);
        expect_bcd("both_bcd");

        // Preload 59:59.99 while stopped, then run through the rollover.
        display_mode = 1'b1;
        force dut.cs_cnt  = 7'd99;
        force dut.sec_cnt = 6'd59;
        force dut.min_cnt = 6'd59;
        cycle();
        cycle();
        release dut.cs_cnt;
        release dut.sec_cnt;
        release dut.min_cnt;
        run_cycles = (WRAP_CS - 1) * T;
        expect_bcd("preload_5959");
        check("preload_bcd_5959", 32'(bcd), 5959);

        pulse_run();
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (run_cycles == WRAP_CS * T) begin
                check("wrap_high", 32'(wrap_pulse), 1);
                hit = 1'b1;
                break;
            end
            check("wrap_low_before", 32'(wrap_pulse), 0);
        end
        check("wrap_seen", 32'(hit), 1);
        expect_bcd("wrap_bcd");
        check("wrap_bcd_zero", 32'(bcd), 0);
        check("wrap_once", 32'(wrap_pulse), 0);
        check("wrap_led", 32'(run_led), 1);
        display_mode = 1'b0;
        repeat (9) cycle();
        expect_bcd("after_wrap_mode0");

        // Asynchronous reset mid-run.
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_bcd", 32'(bcd),        0);
        check("async_rst_led", 32'(run_led),    0);
        check("async_rst_wrap", 32'(wrap_pulse), 0);
        @(negedge clk);
        reset      = 1'b1;
        running    = 1'b0;
        run_cycles = 0;
        repeat (3) cycle();
        check("post_rst_stop", 32'(run_led), 0);
        expect_bcd("post_rst_bcd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
